// File: rtl/rpn_msg_type_demux.sv
// rpn_msg_type_demux
//   Packet-level AXI-Stream demultiplexer. The message type in the low bits
//   of a packet's first beat selects one of NUM_OUTPUTS ports. The packet is
//   then carried through a single full-throughput register slice. Packets
//   whose type matches no port are swallowed and counted.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   HEAD  | next beat is a packet head; classify it by its type field
//   FWD   | mid-packet; every beat goes to the latched port
//   DROP  | mid-packet of an unmatched type; discard beats
//
// Ports
//   i_clk, i_ap_rst_n           clock, asynchronous active-low reset
//   from_network_bridge_*       input stream (tready is the only output)
//   to_out_tvalid/tready        per-port handshake
//   to_out_t{data,keep,id,dest,user,last}
//                               payload shared by all ports
//   o_drop_pulse                one cycle after a dropped packet ends
//   o_drop_count                saturating dropped-packet count
module rpn_msg_type_demux #(
    parameter int AXIS_DATA_WIDTH          = 512,
    parameter int AXIS_KEEP_WIDTH          = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_FROM_NB_TDEST_WIDTH = 16,
    parameter int AXIS_FROM_NB_TUSER_WIDTH = 16,
    parameter int RPN_MSG_TYPE_WIDTH       = 8,
    parameter int NUM_OUTPUTS              = 2,
    // slice 0 = KIP_PUB (0x01), slice 1 = KIP_ACK (0x02)
    parameter logic [NUM_OUTPUTS*RPN_MSG_TYPE_WIDTH-1:0] OUT_MSG_TYPES = {8'h02, 8'h01},
    parameter int DROP_CNT_WIDTH           = 16
) (
    input  logic                                i_clk,
    input  logic                                i_ap_rst_n,

    input  logic                                from_network_bridge_tvalid,
    output logic                                from_network_bridge_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]          from_network_bridge_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]          from_network_bridge_tkeep,
    input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_network_bridge_tid,
    input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_network_bridge_tdest,
    input  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] from_network_bridge_tuser,
    input  logic                                from_network_bridge_tlast,

    output logic [NUM_OUTPUTS-1:0]              to_out_tvalid,
    input  logic [NUM_OUTPUTS-1:0]              to_out_tready,
    output logic [AXIS_DATA_WIDTH-1:0]          to_out_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]          to_out_tkeep,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_out_tid,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_out_tdest,
    output logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] to_out_tuser,
    output logic                                to_out_tlast,

    output logic                                o_drop_pulse,
    output logic [DROP_CNT_WIDTH-1:0]           o_drop_count
);

    localparam int SEL_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    typedef enum logic [1:0] {HEAD, FWD, DROP} state_e;

    state_e                      state_q, state_d;
    logic [SEL_W-1:0]            sel_q, sel_d;
    logic [SEL_W-1:0]            out_sel_q, out_sel_d;
    logic                        valid_q, valid_d;
    logic                        drop_pulse_q;
    logic [DROP_CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;

    logic [AXIS_DATA_WIDTH-1:0]          data_q;
    logic [AXIS_KEEP_WIDTH-1:0]          keep_q;
    logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] id_q;
    logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] dest_q;
    logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] user_q;
    logic                                last_q;

    logic             match_hit;
    logic [SEL_W-1:0] match_idx;
    logic             slice_ready;
    logic             fwd_beat;
    logic [SEL_W-1:0] beat_sel;
    logic             accept;
    logic             load;
    logic             drop_fire;

    // Scan from the top down so the lowest matching index wins.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = NUM_OUTPUTS - 1; i >= 0; i--) begin
            if (from_network_bridge_tdata[RPN_MSG_TYPE_WIDTH-1:0] ==
                OUT_MSG_TYPES[i*RPN_MSG_TYPE_WIDTH +: RPN_MSG_TYPE_WIDTH]) begin
                match_hit = 1'b1;
                match_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        slice_ready = !valid_q || to_out_tready[out_sel_q];
        fwd_beat    = (state_q == FWD) || ((state_q == HEAD) && match_hit);
        beat_sel    = (state_q == FWD) ? sel_q : match_idx;
        // Dropped beats never touch the slice, so they are always accepted.
        from_network_bridge_tready = fwd_beat ? slice_ready : 1'b1;
        accept      = from_network_bridge_tvalid && from_network_bridge_tready;
        load        = accept && fwd_beat;
        drop_fire   = accept && from_network_bridge_tlast && !fwd_beat;

        state_d = state_q;
        sel_d   = sel_q;
        if (accept) begin
            case (state_q)
                HEAD: begin
                    if (!from_network_bridge_tlast) begin
                        if (match_hit) begin
                            state_d = FWD;
                            sel_d   = match_idx;
                        end else begin
                            state_d = DROP;
                        end
                    end
                end
                FWD:     if (from_network_bridge_tlast) state_d = HEAD;
                DROP:    if (from_network_bridge_tlast) state_d = HEAD;
                default: state_d = HEAD;
            endcase
        end

        valid_d   = slice_ready ? load : valid_q;
        out_sel_d = load ? beat_sel : out_sel_q;

        drop_cnt_d = drop_cnt_q;
        if (drop_fire && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            state_q      <= HEAD;
            sel_q        <= '0;
            out_sel_q    <= '0;
            valid_q      <= 1'b0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
            data_q       <= '0;
            keep_q       <= '0;
            id_q         <= '0;
            dest_q       <= '0;
            user_q       <= '0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            out_sel_q    <= out_sel_d;
            valid_q      <= valid_d;
            drop_pulse_q <= drop_fire;
            drop_cnt_q   <= drop_cnt_d;
            // load implies the slice is advancing, so payload never changes under a stall.
            if (load) begin
                data_q <= from_network_bridge_tdata;
                keep_q <= from_network_bridge_tkeep;
                id_q   <= from_network_bridge_tid;
                dest_q <= from_network_bridge_tdest;
                user_q <= from_network_bridge_tuser;
                last_q <= from_network_bridge_tlast;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            to_out_tvalid[i] = valid_q && (out_sel_q == SEL_W'(i));
        end
    end

    assign to_out_tdata  = data_q;
    assign to_out_tkeep  = keep_q;
    assign to_out_tid    = id_q;
    assign to_out_tdest  = dest_q;
    assign to_out_tuser  = user_q;
    assign to_out_tlast  = last_q;
    assign o_drop_pulse  = drop_pulse_q;
    assign o_drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_rpn_msg_type_demux.sv
module tb_rpn_msg_type_demux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main DUT: 2 ports (0x01 -> 0, 0x02 -> 1), 2-bit drop counter
    logic        in_tvalid, in_tready, in_tlast;
    logic [31:0] in_tdata;
    logic [3:0]  in_tkeep;
    logic [15:0] in_tid, in_tdest, in_tuser;
    logic [1:0]  out_tvalid, out_tready;
    logic [31:0] out_tdata;
    logic [3:0]  out_tkeep;
    logic [15:0] out_tid, out_tdest, out_tuser;
    logic        out_tlast;
    logic        drop_pulse;
    logic [1:0]  drop_count;

    rpn_msg_type_demux #(
        .AXIS_DATA_WIDTH(32), .AXIS_KEEP_WIDTH(4),
        .AXIS_FROM_NB_TDEST_WIDTH(16), .AXIS_FROM_NB_TUSER_WIDTH(16),
        .RPN_MSG_TYPE_WIDTH(8), .NUM_OUTPUTS(2),
        .OUT_MSG_TYPES(16'h0201), .DROP_CNT_WIDTH(2)
    ) dut (
        .i_clk(clk), .i_ap_rst_n(rst_n),
        .from_network_bridge_tvalid(in_tvalid), .from_network_bridge_tready(in_tready),
        .from_network_bridge_tdata(in_tdata), .from_network_bridge_tkeep(in_tkeep),
        .from_network_bridge_tid(in_tid), .from_network_bridge_tdest(in_tdest),
        .from_network_bridge_tuser(in_tuser), .from_network_bridge_tlast(in_tlast),
        .to_out_tvalid(out_tvalid), .to_out_tready(out_tready),
        .to_out_tdata(out_tdata), .to_out_tkeep(out_tkeep), .to_out_tid(out_tid),
        .to_out_tdest(out_tdest), .to_out_tuser(out_tuser), .to_out_tlast(out_tlast),
        .o_drop_pulse(drop_pulse), .o_drop_count(drop_count)
    );

    // second DUT: 4 ports with types {A,B,A,C} = {0x10,0x20,0x10,0x30}
    logic        b_tvalid, b_tready, b_tlast;
    logic [31:0] b_tdata;
    logic [3:0]  b_tkeep;
    logic [15:0] b_tid, b_tdest, b_tuser;
    logic [3:0]  b_out_tvalid, b_out_tready;
    logic [31:0] b_out_tdata;
    logic [3:0]  b_out_tkeep;
    logic [15:0] b_out_tid, b_out_tdest, b_out_tuser;
    logic        b_out_tlast;
    logic        b_drop_pulse;
    logic [15:0] b_drop_count;

    rpn_msg_type_demux #(
        .AXIS_DATA_WIDTH(32), .AXIS_KEEP_WIDTH(4),
        .AXIS_FROM_NB_TDEST_WIDTH(16), .AXIS_FROM_NB_TUSER_WIDTH(16),
        .RPN_MSG_TYPE_WIDTH(8), .NUM_OUTPUTS(4),
        .OUT_MSG_TYPES(32'h30102010), .DROP_CNT_WIDTH(16)
    ) dut4 (
        .i_clk(clk), .i_ap_rst_n(rst_n),
        .from_network_bridge_tvalid(b_tvalid), .from_network_bridge_tready(b_tready),
        .from_network_bridge_tdata(b_tdata), .from_network_bridge_tkeep(b_tkeep),
        .from_network_bridge_tid(b_tid), .from_network_bridge_tdest(b_tdest),
        .from_network_bridge_tuser(b_tuser), .from_network_bridge_tlast(b_tlast),
        .to_out_tvalid(b_out_tvalid), .to_out_tready(b_out_tready),
        .to_out_tdata(b_out_tdata), .to_out_tkeep(b_out_tkeep), .to_out_tid(b_out_tid),
        .to_out_tdest(b_out_tdest), .to_out_tuser(b_out_tuser), .to_out_tlast(b_out_tlast),
        .o_drop_pulse(b_drop_pulse), .o_drop_count(b_drop_count)
    );

    int n_vec = 0;
    int n_err = 0;
    bit lat_chk = 1'b0;
    int pulse_cnt = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        last;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] snap;

    // sideband fields are derived from tdata so the scoreboard can rebuild them
    function automatic logic [51:0] side(input logic [31:0] d);
        return {d[11:8], d[23:8], d[31:16], d[27:12]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] typ, input logic [23:0] tag, input logic last,
                        input int port, output int waits);
        logic acc;
        logic [31:0] d;
        d = {tag, typ};
        in_tvalid = 1'b1;
        in_tdata  = d;
        {in_tkeep, in_tid, in_tdest, in_tuser} = side(d);
        in_tlast  = last;
        acc   = 1'b0;
        waits = 0;
        while (!acc && waits < 50) begin
            @(negedge clk);
            acc = in_tready;
            @(posedge clk);
            waits++;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: beat 0x%0h not accepted in %0d cycles", d, waits);
        end
        #1;
        in_tvalid = 1'b0;
        if (acc && port >= 0) sb.push_back('{port, d, last, cyc, lat_chk});
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic b_send(input logic [7:0] typ, input logic [3:0] exp_valid);
        b_tvalid = 1'b1;
        b_tdata  = {24'h0E0000, typ};
        @(negedge clk);
        check("dup_in_tready", b_tready, 1);
        @(posedge clk);
        #1;
        b_tvalid = 1'b0;
        @(negedge clk);
        check("dup_valid", b_out_tvalid, exp_valid);
        check("dup_data", b_out_tdata, {24'h0E0000, typ});
        check("dup_side", {b_out_tkeep, b_out_tid, b_out_tdest}, {4'h3, 16'h1234, 16'h5678});
        check("dup_misc", {b_out_tuser, b_out_tlast, b_drop_pulse, b_drop_count},
              {16'h9ABC, 1'b1, 1'b0, 16'h0000});
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_tvalid != 2'b00) check("onehot", $countones(out_tvalid), 1);
            for (int i = 0; i < 2; i++) begin
                if (out_tvalid[i] && out_tready[i]) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: port %0d data 0x%0h, expected no beat", i, out_tdata);
                    end else begin
                        mon_e = sb.pop_front();
                        check("port", i, mon_e.port);
                        check("tdata", out_tdata, mon_e.data);
                        check("tlast", out_tlast, mon_e.last);
                        check("sideband", {out_tkeep, out_tid, out_tdest, out_tuser}, side(mon_e.data));
                        if (mon_e.lat) check("latency", cyc, mon_e.cyc);
                    end
                end
            end
            if (drop_pulse) pulse_cnt++;
        end
    end

    initial begin
        int w;
        int c0;
        int p0;
        in_tvalid = 0; in_tdata = 0; in_tkeep = 0; in_tid = 0; in_tdest = 0; in_tuser = 0; in_tlast = 0;
        out_tready = 2'b11;
        b_tvalid = 0; b_tdata = 0; b_tkeep = 4'h3; b_tid = 16'h1234; b_tdest = 16'h5678;
        b_tuser = 16'h9ABC; b_tlast = 1'b1; b_out_tready = 4'hF;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_valid", out_tvalid, 0);
        check("rst_payload", {out_tdata, out_tlast}, 0);
        check("rst_side", {out_tkeep, out_tid, out_tdest, out_tuser}, 0);
        check("rst_drop", {drop_pulse, drop_count}, 0);
        check("rst_valid4", b_out_tvalid, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic routing: later beats carry KIP_ACK but follow the head to port 0
        lat_chk = 1'b1;
        send(8'h01, 24'h000A01, 1'b0, 0, w);
        send(8'h02, 24'h000A02, 1'b0, 0, w);
        send(8'h02, 24'h000A03, 1'b1, 0, w);
        drain();

        // alternating single-beat packets, no bubbles
        c0 = cyc;
        for (int k = 0; k < 8; k++) begin
            send((k % 2) ? 8'h02 : 8'h01, 24'h0B0000 + 24'(k), 1'b1, k % 2, w);
        end
        check("no_bubble", cyc - c0, 8);
        drain();

        // backpressure on port 1
        lat_chk = 1'b0;
        out_tready = 2'b01;
        fork
            begin
                for (int k = 0; k < 4; k++) send(8'h02, 24'h0C0000 + 24'(k), k == 3, 1, w);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                snap = out_tdata;
                for (int j = 0; j < 5; j++) begin
                    if (j > 0) @(negedge clk);
                    check("stall_valid", out_tvalid, 2'b10);
                    check("stall_data", out_tdata, snap);
                    check("stall_in_tready", in_tready, 0);
                end
                @(posedge clk);
                #1;
                out_tready = 2'b11;
            end
        join
        drain();

        // drop and saturation
        lat_chk = 1'b1;
        p0 = pulse_cnt;
        send(8'h7F, 24'h0D0000, 1'b0, -1, w);
        check("drop_ready0", w, 1);
        send(8'h7F, 24'h0D0001, 1'b1, -1, w);
        check("drop_ready1", w, 1);
        @(negedge clk);
        #1;
        check("drop_pulse_hi", drop_pulse, 1);
        check("drop_count1", drop_count, 1);
        @(negedge clk);
        #1;
        check("drop_pulse_lo", drop_pulse, 0);
        check("drop_pulse_once", pulse_cnt - p0, 1);
        @(posedge clk);
        #1;
        send(8'h01, 24'h0D0002, 1'b1, 0, w);
        for (int k = 0; k < 5; k++) send(8'h55, 24'h0D0010 + 24'(k), 1'b1, -1, w);
        @(negedge clk);
        #1;
        check("drop_saturate", drop_count, 3);
        check("drop_pulse_total", pulse_cnt - p0, 6);
        @(posedge clk);
        #1;
        drain();

        // duplicate types: A goes to port 0 only, B to 1, C to 3
        b_send(8'h10, 4'b0001);
        b_send(8'h20, 4'b0010);
        b_send(8'h30, 4'b1000);

        // reset in the middle of a stalled packet
        lat_chk = 1'b0;
        out_tready = 2'b01;
        send(8'h02, 24'h0F0000, 1'b0, 1, w);
        in_tvalid = 1'b1;
        in_tdata  = {24'h0F0001, 8'h02};
        {in_tkeep, in_tid, in_tdest, in_tuser} = side(in_tdata);
        in_tlast  = 1'b0;
        @(negedge clk);
        check("rmp_in_tready", in_tready, 0);
        check("rmp_valid_before", out_tvalid, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check("rmp_valid", out_tvalid, 0);
        check("rmp_count", drop_count, 0);
        check("rmp_payload", {out_tdata, out_tlast}, 0);
        sb.delete();
        in_tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_tready = 2'b11;
        lat_chk = 1'b1;
        send(8'h01, 24'h0F0002, 1'b1, 0, w);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rpn_msg_type_demux.md
# rpn_msg_type_demux

Packet-level, parametrised AXI-Stream demultiplexer between the network bridge and the RPN protocol engines (KIP TX/RX, WNN, and others). It classifies each incoming packet by the message-type field in the low bits of its first beat and steers the whole packet to one of `NUM_OUTPUTS` ports through a one-stage, full-throughput register slice. Packets whose type matches no port are consumed and counted.

## Interface
Parameters:
- `AXIS_DATA_WIDTH`, 512: tdata width.
- `AXIS_KEEP_WIDTH`, `AXIS_DATA_WIDTH/8`: tkeep width.
- `AXIS_FROM_NB_TDEST_WIDTH`, 16: tid and tdest width.
- `AXIS_FROM_NB_TUSER_WIDTH`, 16: tuser width.
- `RPN_MSG_TYPE_WIDTH`, 8: width of the type field at `tdata[RPN_MSG_TYPE_WIDTH-1:0]`.
- `NUM_OUTPUTS`, 2: number of output ports, minimum 1.
- `OUT_MSG_TYPES`, {KIP_PUB, KIP_ACK}: packed `NUM_OUTPUTS*RPN_MSG_TYPE_WIDTH` vector. Slice `i` is the type routed to output `i`.
- `DROP_CNT_WIDTH`, 16: width of the drop counter.

Ports:
- `i_clk`, input, 1: clock.
- `i_ap_rst_n`, input, 1: asynchronous, active-low reset.
- `from_network_bridge_tvalid/tready/tdata/tkeep/tid/tdest/tuser/tlast`, in/out, standard widths: input AXIS. tready is the only output.
- `to_out_tvalid`, output, `NUM_OUTPUTS`: per-port valid.
- `to_out_tready`, input, `NUM_OUTPUTS`: per-port ready.
- `to_out_tdata/tkeep/tid/tdest/tuser/tlast`, output, single-port widths: shared payload, common to all ports.
- `o_drop_pulse`, output, 1: one-cycle pulse when a dropped packet's last beat is consumed.
- `o_drop_count`, output, `DROP_CNT_WIDTH`: saturating count of dropped packets.

## Operation
- The FSM has three states: `HEAD`, `FWD`, `DROP`. Reset state is `HEAD`.
- **HEAD:** decode the type of the current beat. If the type equals slice `i`, the selected port is `i`. If several slices match, the lowest index wins. If no slice matches, the beat is a drop beat.
- **Accepting a head beat** (tvalid & tready):
  - Forward, no tlast: latch `r_sel`, go to `FWD`.
  - Forward, with tlast: stay in `HEAD`.
  - Drop, no tlast: go to `DROP`.
  - Drop, with tlast: stay in `HEAD` and fire the drop event.
- **FWD:** every beat goes to `r_sel`, regardless of its tdata. Return to `HEAD` on an accepted tlast beat.
- **DROP:** input tready is 1. Beats are discarded and never enter the register slice. On an accepted tlast beat, fire the drop event and return to `HEAD`.
- **Register slice:** one shared payload register, `r_valid`, and `r_out_sel`.
  - `to_out_tvalid[i] = r_valid && (r_out_sel == i)`.
  - The slice advances when it is empty or its selected port is ready.
- **Drop event:** `o_drop_pulse` is 1 for one cycle. `o_drop_count` increments and saturates at all-ones.
- Only the first beat's type field is examined. Later beats are never reclassified.

## Timing
- **Latency:** an accepted input beat appears at the output on the next cycle.
- **Throughput:** one beat per cycle while the destination port holds tready high.
- **Input ready:**
  - `HEAD` or `FWD` with the beat forwarded: tready = `!r_valid || to_out_tready[r_out_sel]`. This path is combinational.
  - `DROP`, or `HEAD` with an unmatched type: tready = 1.
- **Stall:** while `r_valid` is high and the selected port is not ready, all output signals hold stable.
- **Head-of-line blocking:** a stalled port blocks every packet behind it.
- **Port switch at a packet boundary:** a head beat for port B may enter while port A's last beat is leaving in the same cycle. No bubble is inserted.
- **Reset values:**
  - All `to_out_tvalid` = 0.
  - All payload outputs = 0.
  - `o_drop_pulse` = 0, `o_drop_count` = 0.
  - FSM = `HEAD`, `r_sel` = 0.
- **Reset during a packet:** any beat held in the register is discarded. The next beat after reset is treated as a head and reclassified.
- **Counter:** `o_drop_count` updates on the cycle after the drop event, at the same edge as the `o_drop_pulse` assertion.

## Test plan
- **Basic routing.** Default params, sinks always ready. Send a 3-beat packet with type KIP_PUB on beat 0, where beats 1–2 carry type KIP_ACK in their low bits. Required: all 3 beats appear on port 0 only, back-to-back, 1 cycle after input, with tlast on beat 3. Port 1 valid stays 0.
- **Alternating single-beat packets.** Single-beat packets alternate KIP_PUB and KIP_ACK for 8 cycles. Required: ports 0 and 1 alternate, 8 beats in 8 cycles with no bubble.
- **Backpressure.** Port 1 tready is low for 5 cycles during a 4-beat KIP_ACK packet. Required: output payload holds stable, input tready is 0 while the register is full, no beats are lost or duplicated, and order is preserved.
- **Drop and saturation.** Send a 2-beat packet of type 0x7F, then a KIP_PUB packet, with `DROP_CNT_WIDTH` = 2. Required: the 2 beats are accepted with tready = 1, nothing is output, `o_drop_pulse` fires once and the count becomes 1, then the KIP_PUB packet goes to port 0. Five more drops leave the count saturated at 3.
- **Duplicate types.** `NUM_OUTPUTS` = 4 with types {A, B, A, C}. A type-A packet goes to port 0 only.
- **Reset mid-packet.** Assert `i_ap_rst_n` low in beat 2 of a 4-beat KIP_ACK packet while port 1 is stalled. Required: all valids are 0 immediately and the count is 0. After release, a head beat of type KIP_PUB routes to port 0.
